// File: rtl/kfpga_config_loader_if.sv
// Bitstream word stream in, committed configuration and status out.
// Parameters must match the loader instance that uses this bundle.
interface kfpga_config_loader_if #(
  parameter int CONFIG_WIDTH = 2034,
  parameter int WORD_WIDTH   = 8
);
  logic                    start;
  logic [WORD_WIDTH-1:0]   word_in;
  logic                    word_valid;
  logic                    word_ready;
  logic [CONFIG_WIDTH-1:0] config_out;
  logic                    busy;
  logic                    done;
  logic                    error;

  modport master (
    output start, word_in, word_valid,
    input  word_ready, config_out, busy, done, error
  );

  modport slave (
    input  start, word_in, word_valid,
    output word_ready, config_out, busy, done, error
  );
endinterface

// File: rtl/kfpga_config_loader.sv
// Shifts bitstream words into a shadow register and commits them atomically to config_out.
// Optional trailing XOR checksum word: define KFPGA_CONFIG_CHECKSUM_EN.
module kfpga_config_loader #(
  parameter int CONFIG_WIDTH = 2034,
  parameter int WORD_WIDTH   = 8
) (
  input logic                  clock,
  input logic                  reset,
  kfpga_config_loader_if.slave bus
);
  localparam int NWORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int CW     = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

`ifdef KFPGA_CONFIG_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CONFIG_WIDTH-1:0] config_q;
  logic                    done_q;
  logic                    ready;
  logic                    commit;

`ifdef KFPGA_CONFIG_CHECKSUM_EN
  logic [WORD_WIDTH-1:0]   csum_q, csum_d;
  logic                    reject;
  logic                    error_q;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    ready    = 1'b0;
    commit   = 1'b0;
`ifdef KFPGA_CONFIG_CHECKSUM_EN
    csum_d   = csum_q;
    reject   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = LOAD;
          count_d  = '0;
          shadow_d = '0;
`ifdef KFPGA_CONFIG_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      LOAD: begin
        ready = 1'b1;
        // A restart outranks every word, including the final one.
        if (bus.start) begin
          count_d  = '0;
          shadow_d = '0;
`ifdef KFPGA_CONFIG_CHECKSUM_EN
          csum_d   = '0;
`endif
        end else if (bus.word_valid) begin
          // Bits of the last word beyond CONFIG_WIDTH have no destination and drop out here.
          for (int b = 0; b < CONFIG_WIDTH; b++) begin
            if (count_q == CW'(b / WORD_WIDTH)) shadow_d[b] = bus.word_in[b % WORD_WIDTH];
          end
          count_d = count_q + 1'b1;
`ifdef KFPGA_CONFIG_CHECKSUM_EN
          csum_d  = csum_q ^ bus.word_in;
          if (count_q == LAST) state_d = CHECK;
`else
          if (count_q == LAST) begin
            commit  = 1'b1;
            state_d = IDLE;
          end
`endif
        end
      end
`ifdef KFPGA_CONFIG_CHECKSUM_EN
      CHECK: begin
        ready = 1'b1;
        if (bus.start) begin
          state_d  = LOAD;
          count_d  = '0;
          shadow_d = '0;
          csum_d   = '0;
        end else if (bus.word_valid) begin
          state_d = IDLE;
          if (bus.word_in == csum_q) commit = 1'b1;
          else                       reject = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      config_q <= '0;
      done_q   <= 1'b0;
`ifdef KFPGA_CONFIG_CHECKSUM_EN
      csum_q   <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      done_q   <= commit;
      if (commit) config_q <= shadow_d;
`ifdef KFPGA_CONFIG_CHECKSUM_EN
      csum_q   <= csum_d;
      error_q  <= reject;
`endif
    end
  end

  assign bus.word_ready = ready;
  assign bus.busy       = ready;
  assign bus.config_out = config_q;
  assign bus.done       = done_q;
`ifdef KFPGA_CONFIG_CHECKSUM_EN
  assign bus.error      = error_q;
`else
  assign bus.error      = 1'b0;
`endif
endmodule

// File: tb/tb_kfpga_config_loader.sv
// Scoreboarded bench for kfpga_config_loader at CONFIG_WIDTH=20, WORD_WIDTH=8 (three words).
// Define KFPGA_CONFIG_CHECKSUM_EN for both bench and RTL to exercise the checksum build.
module tb_kfpga_config_loader;
  logic clock = 1'b0;
  logic reset = 1'b1;

  kfpga_config_loader_if #(.CONFIG_WIDTH(20), .WORD_WIDTH(8)) bus ();

  kfpga_config_loader #(.CONFIG_WIDTH(20), .WORD_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        err;
    logic [19:0] cfg;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks    = 0;
  int          errors    = 0;
  int          done_cnt  = 0;
  int          err_cnt   = 0;
  logic [19:0] model_cfg = '0;

  // Every done/error pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.done && bus.error) begin
        checks++; errors++;
        $display("FAIL done_error_overlap: both high at %0t", $time);
      end
      if (bus.done || bus.error) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: done=%b error=%b config_out=%h, required no pulse", bus.done, bus.error, bus.config_out);
        end else begin
          e = q.pop_front();
          if (bus.error !== e.err || bus.done !== !e.err || bus.config_out !== e.cfg) begin
            errors++;
            $display("FAIL commit_event: done=%b error=%b config_out=%h, required error=%b config_out=%h",
                     bus.done, bus.error, bus.config_out, e.err, e.cfg);
          end
        end
      end
      if (bus.done)  done_cnt++;
      if (bus.error) err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic with_start);
    int n = 0;
    while (bus.word_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (bus.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: word_ready=%b, required 1", bus.word_ready);
    end
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    bus.start      = with_start;
    @(negedge clock);
    bus.word_valid = 1'b0;
    bus.start      = 1'b0;
  endtask

  // Sends a full valid load (plus checksum word in that build) and predicts its commit.
  task automatic load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int gap);
    logic [23:0] full;
    exp_t        x;
    full  = {c, b, a};
    x.err = 1'b0;
    x.cfg = full[19:0];
    send_word(a, 1'b0); idle(gap);
    send_word(b, 1'b0); idle(gap);
`ifdef KFPGA_CONFIG_CHECKSUM_EN
    send_word(c, 1'b0); idle(gap);
    checks++;
    if (bus.config_out !== model_cfg) begin
      errors++;
      $display("FAIL hold_during_load: config_out=%h, required %h", bus.config_out, model_cfg);
    end
    q.push_back(x);
    send_word(a ^ b ^ c, 1'b0);
`else
    checks++;
    if (bus.config_out !== model_cfg) begin
      errors++;
      $display("FAIL hold_during_load: config_out=%h, required %h", bus.config_out, model_cfg);
    end
    q.push_back(x);
    send_word(c, 1'b0);
`endif
    model_cfg = x.cfg;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (bus.config_out !== 20'h00000 || bus.busy !== 1'b0 || bus.word_ready !== 1'b0 ||
        bus.done !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: config_out=%h busy=%b word_ready=%b done=%b error=%b, required all 0",
               bus.config_out, bus.busy, bus.word_ready, bus.done, bus.error);
    end
    reset = 1'b0;
    idle(2);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.word_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_entry: busy=%b word_ready=%b, required 1 1", bus.busy, bus.word_ready);
    end
    load(8'hA5, 8'h3C, 8'hFF, 0);
    checks++;
    if (bus.config_out !== 20'hF3CA5 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_commit: config_out=%h done=%b, required f3ca5 1", bus.config_out, bus.done);
    end
    idle(1);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL b2b_single_done: done=%b busy=%b pulses=%0d, required 0 0 1", bus.done, bus.busy, done_cnt - d0);
    end
  endtask

  task automatic test_gapped();
    pulse_start();
    load(8'h12, 8'h34, 8'h56, 0);
    idle(1);
    pulse_start();
    load(8'hA5, 8'h3C, 8'hFF, 2);
    idle(1);
    checks++;
    if (bus.config_out !== 20'hF3CA5) begin
      errors++;
      $display("FAIL gapped_commit: config_out=%h, required f3ca5", bus.config_out);
    end
  endtask

  task automatic test_abort();
    int d0 = done_cnt;
    pulse_start();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    pulse_start();
    load(8'h01, 8'h02, 8'h03, 0);
    idle(2);
    checks++;
    if (bus.config_out !== 20'h30201 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL abort_restart: config_out=%h pulses=%0d, required 30201 1", bus.config_out, done_cnt - d0);
    end
  endtask

  task automatic test_final_start();
    int d0 = done_cnt;
    pulse_start();
    send_word(8'h0A, 1'b0);
    send_word(8'h0B, 1'b0);
`ifdef KFPGA_CONFIG_CHECKSUM_EN
    send_word(8'h0C, 1'b0);
    send_word(8'h0A ^ 8'h0B ^ 8'h0C, 1'b1);
`else
    send_word(8'h0C, 1'b1);
`endif
    checks++;
    if (bus.busy !== 1'b1 || bus.config_out !== model_cfg) begin
      errors++;
      $display("FAIL final_start_priority: busy=%b config_out=%h, required 1 %h", bus.busy, bus.config_out, model_cfg);
    end
    load(8'hC1, 8'hC2, 8'hC3, 1);
    idle(2);
    checks++;
    if (bus.config_out !== 20'h3C2C1 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL final_start_reload: config_out=%h pulses=%0d, required 3c2c1 1", bus.config_out, done_cnt - d0);
    end
  endtask

  task automatic test_idle_valid();
    int d0 = done_cnt;
    bus.word_in    = 8'h77;
    bus.word_valid = 1'b1;
    idle(4);
    checks++;
    if (bus.busy !== 1'b0 || bus.word_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid_state: busy=%b word_ready=%b, required 0 0", bus.busy, bus.word_ready);
    end
    bus.word_valid = 1'b0;
    idle(2);
    checks++;
    if (bus.config_out !== model_cfg || done_cnt != d0) begin
      errors++;
      $display("FAIL idle_valid_ignored: config_out=%h pulses=%0d, required %h 0", bus.config_out, done_cnt - d0, model_cfg);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.config_out !== 20'h00000 || bus.busy !== 1'b0 || bus.word_ready !== 1'b0 ||
        bus.done !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: config_out=%h busy=%b word_ready=%b done=%b error=%b, required all 0",
               bus.config_out, bus.busy, bus.word_ready, bus.done, bus.error);
    end
    model_cfg = '0;
    @(negedge clock);
    reset = 1'b0;
    idle(2);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_needs_start: busy=%b, required 0", bus.busy);
    end
    pulse_start();
    load(8'hA5, 8'h3C, 8'hFF, 0);
    idle(1);
    checks++;
    if (bus.config_out !== 20'hF3CA5) begin
      errors++;
      $display("FAIL post_reset_load: config_out=%h, required f3ca5", bus.config_out);
    end
  endtask

`ifdef KFPGA_CONFIG_CHECKSUM_EN
  task automatic test_checksum();
    exp_t x;
    int   e0 = err_cnt;
    x.err = 1'b1;
    x.cfg = model_cfg;
    pulse_start();
    send_word(8'hA5, 1'b0); send_word(8'h3C, 1'b0); send_word(8'hFF, 1'b0);
    q.push_back(x);
    send_word(8'h67, 1'b0);
    idle(1);
    pulse_start();
    send_word(8'h01, 1'b0); send_word(8'h02, 1'b0); send_word(8'h03, 1'b0);
    q.push_back(x);
    send_word(8'h01, 1'b0);
    idle(2);
    checks++;
    if (err_cnt != e0 + 2 || bus.config_out !== 20'hF3CA5 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL checksum_reject: errors=%0d config_out=%h busy=%b, required 2 f3ca5 0",
               err_cnt - e0, bus.config_out, bus.busy);
    end
  endtask
`endif

  initial begin
    bus.start      = 1'b0;
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_abort();
    test_final_start();
    test_idle_valid();
    test_reset_mid_load();
`ifdef KFPGA_CONFIG_CHECKSUM_EN
    test_checksum();
`endif
    idle(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected events never seen, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kfpga_config_loader.md
KFPGA_CONFIG_LOADER -- requirements
Module: kfpga_config_loader

Interface
REQ-001 Parameter CONFIG_WIDTH, default 2034, SHALL set the width of the parallel configuration vector driven into the core.
REQ-002 Parameter WORD_WIDTH, default 8, SHALL set the width of one bitstream word; NWORDS = ceil(CONFIG_WIDTH/WORD_WIDTH).
REQ-003 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  input  1  SHALL be a one-cycle request to begin loading a new bitstream.
REQ-006 word_in  input  WORD_WIDTH  SHALL carry the bitstream word.
REQ-007 word_valid  input  1  SHALL qualify word_in.
REQ-008 word_ready  output  1  SHALL indicate the loader accepts word_in this cycle.
REQ-009 config_out  output  CONFIG_WIDTH  SHALL be the committed configuration, connected to the core config_in.
REQ-010 busy  output  1  SHALL be high while a load is in progress.
REQ-011 done  output  1  SHALL pulse for one cycle when a new configuration is committed.
REQ-012 error  output  1  SHALL pulse for one cycle when a load is rejected (checksum build only; tied 0 otherwise).

Function
REQ-013 The FSM SHALL have states IDLE, LOAD and (checksum build only) CHECK.
REQ-014 IDLE: word_ready = 0 and busy = 0; start SHALL move the FSM to LOAD with the word counter cleared.
REQ-015 LOAD: word_ready = 1 and busy = 1; a word SHALL be accepted only on a cycle with word_valid = 1 and word_ready = 1.
REQ-016 Accepted word k (0-based) SHALL map to config bits [k*WORD_WIDTH +: WORD_WIDTH]; bits of the last word above CONFIG_WIDTH-1 SHALL be discarded.
REQ-017 Words SHALL be collected in a shadow register; config_out SHALL NOT change while loading.
REQ-018 On acceptance of word NWORDS-1, config_out SHALL update from the shadow register on the next rising edge, done SHALL pulse in that same cycle, and the FSM SHALL return to IDLE (commit is atomic).
REQ-019 A start in LOAD or CHECK SHALL abort the load, clear the counter and shadow register, and restart LOAD; config_out SHALL be unchanged.
REQ-020 start asserted in the same cycle as acceptance of the final word SHALL take priority: no commit, no done, load restarts.
REQ-021 word_valid in IDLE SHALL be ignored (no state change).
REQ-022 The counter SHALL be ceil(log2(NWORDS+1)) bits wide and SHALL NOT wrap; it saturates at NWORDS via the state change.
REQ-023 done and error SHALL never be high in the same cycle.

Reset
REQ-024 reset asserted SHALL immediately force: FSM = IDLE, counter = 0, shadow = 0, config_out = 0, word_ready = 0, busy = 0, done = 0, error = 0.
REQ-025 reset during LOAD SHALL discard the partial load; after deassertion a fresh start is required.

Configuration
REQ-026 Macro KFPGA_CONFIG_CHECKSUM_EN defined: after word NWORDS-1 the FSM SHALL enter CHECK, accept one extra word (same handshake), and compare it with the XOR of all NWORDS accepted words.
REQ-027 In CHECK on a match, the commit and done SHALL occur on the next edge as in REQ-018; on a mismatch, error SHALL pulse, config_out SHALL be unchanged, and the FSM SHALL return to IDLE.
REQ-028 Macro undefined: there is no CHECK state, the commit follows REQ-018, and error SHALL be constant 0.

Verification (CONFIG_WIDTH=20, WORD_WIDTH=8, NWORDS=3)
REQ-029 reset pulse -> config_out = 20'h00000, busy = 0, word_ready = 0, done = 0.
REQ-030 start, then words 0xA5, 0x3C, 0xFF back-to-back (no checksum build) -> config_out = 20'hF3CA5 one cycle after the third handshake, with done high for exactly that cycle.
REQ-031 Same words with word_valid gapped by 2 idle cycles each -> identical result; config_out holds its old value until the commit.
REQ-032 start, 0x11, 0x22, then start again, then 0x01, 0x02, 0x03 -> config_out = 20'h30201; there is exactly one done pulse.
REQ-033 Checksum build: 0xA5, 0x3C, 0xFF, 0x66 -> commit 20'hF3CA5 with done; repeating with 0x67 as the final word -> error pulse, config_out unchanged.
REQ-034 reset asserted after the 2nd word -> all outputs go to reset values asynchronously; a following full load commits normally.
